// File: rtl/mac_window_ctrl.sv
// mac_window_ctrl: sequences one windowed dot product through the shared MAC core.
// An unsigned sample window from the capture ring buffer is streamed against a
// signed coefficient table, and the final accumulator is returned saturated to OUT_W bits.
module mac_window_ctrl #(
    parameter int A_W     = 8,
    parameter int B_W     = 18,
    parameter int P_W     = 96,
    parameter int SADDR_W = 11,
    parameter int CADDR_W = 8,
    parameter int MAC_LAT = 2,
    parameter int OUT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [SADDR_W-1:0] base_addr_i,
    input  logic [CADDR_W:0]   len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [OUT_W-1:0]   result_o,
    output logic               sat_o,
    output logic               smp_rd_en_o,
    output logic [SADDR_W-1:0] smp_raddr_o,
    input  logic [A_W-1:0]     smp_rdata_i,
    output logic               coef_rd_en_o,
    output logic [CADDR_W-1:0] coef_raddr_o,
    input  logic [B_W-1:0]     coef_rdata_i,
    output logic               mac_ce_o,
    output logic               mac_reload_o,
    output logic [A_W-1:0]     mac_a_o,
    output logic [B_W-1:0]     mac_b_o,
    input  logic [P_W-1:0]     mac_p_i
);

    typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_e;

    localparam int LEN_W   = CADDR_W + 1;
    localparam int DRAIN_W = $clog2(MAC_LAT + 3);
    localparam logic [LEN_W-1:0]   MAX_LEN    = {1'b1, {CADDR_W{1'b0}}};
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MAC_LAT + 2);

    state_e               state_q, state_d;
    logic [SADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     pairCnt_q, pairCnt_d;
    logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
    logic                 captureEn;
    logic                 abortHit;
    logic                 feedActive;
    logic                 rdValid_q;
    logic [A_W-1:0]       macA_q;
    logic [B_W-1:0]       macB_q;
    logic [OUT_W-1:0]     result_q;
    logic                 sat_q;
    logic                 done_q;
    logic                 macCe_q;
    logic [OUT_W-1:0]     satResult;
    logic                 satFlag;
    logic [P_W-OUT_W:0]   upperBits;

    assign abortHit   = abort_i && (state_q != IDLE);
    assign feedActive = (state_q == FEED);

    // Sequencer registers: state, captured window parameters, pair and drain counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            pairCnt_q  <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            pairCnt_q  <= pairCnt_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // Next-state logic; abort overrides every transition and a busy start is simply not looked at
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        pairCnt_d  = pairCnt_q;
        drainCnt_d = drainCnt_q;
        captureEn  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    base_d    = base_addr_i;
                    len_d     = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                    pairCnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (len_q == '0) begin
                    state_d    = DRAIN;
                    drainCnt_d = DRAIN_INIT;
                end else begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (pairCnt_q == len_q - LEN_W'(1)) begin
                    state_d    = DRAIN;
                    drainCnt_d = DRAIN_INIT;
                end else begin
                    pairCnt_d = pairCnt_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d   = IDLE;
                    captureEn = 1'b1;
                end else begin
                    drainCnt_d = drainCnt_q - DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (abortHit) begin
            state_d   = IDLE;
            captureEn = 1'b0;
        end
    end

    // Operand stage: memory data is registered onto the MAC only in cycles that carry a real pair
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdValid_q <= 1'b0;
            macA_q    <= '0;
            macB_q    <= '0;
        end else begin
            rdValid_q <= feedActive && !abortHit;
            if (rdValid_q && !abortHit) begin
                macA_q <= smp_rdata_i;
                macB_q <= coef_rdata_i;
            end else begin
                macA_q <= '0;
                macB_q <= '0;
            end
        end
    end

    // Clip the wide accumulator: it fits only if all bits above the result sign match it
    always_comb begin
        upperBits = mac_p_i[P_W-1:OUT_W-1];
        satResult = mac_p_i[OUT_W-1:0];
        satFlag   = 1'b0;
        if (!((&upperBits) || !(|upperBits))) begin
            satFlag   = 1'b1;
            satResult = mac_p_i[P_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Result capture and done pulse; the clock enable comes up one clock after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            macCe_q  <= 1'b0;
        end else begin
            done_q  <= captureEn;
            macCe_q <= 1'b1;
            if (captureEn) begin
                result_q <= satResult;
                sat_q    <= satFlag;
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign sat_o        = sat_q;
    assign smp_rd_en_o  = feedActive;
    assign smp_raddr_o  = feedActive ? (base_q + SADDR_W'(pairCnt_q)) : '0;
    assign coef_rd_en_o = feedActive;
    assign coef_raddr_o = feedActive ? pairCnt_q[CADDR_W-1:0] : '0;
    assign mac_ce_o     = macCe_q;
    assign mac_reload_o = (state_q == LOAD);
    assign mac_a_o      = macA_q;
    assign mac_b_o      = macB_q;

endmodule

// File: tb/tb_mac_window_ctrl.sv
// tb_mac_window_ctrl: drives mac_window_ctrl against behavioural sample/coefficient
// memories and a pipelined MAC, and compares each run with a plain-arithmetic dot product.
module tb_mac_window_ctrl;

    localparam int A_W        = 8;
    localparam int B_W        = 18;
    localparam int P_W        = 96;
    localparam int SADDR_W    = 11;
    localparam int CADDR_W    = 8;
    localparam int MAC_LAT    = 2;
    localparam int OUT_W      = 32;
    localparam int SMP_DEPTH  = 1 << SADDR_W;
    localparam int COEF_DEPTH = 1 << CADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [SADDR_W-1:0] baseAddr = '0;
    logic [CADDR_W:0]   lenIn = '0;
    logic               busy, done, sat;
    logic [OUT_W-1:0]   result;
    logic               smpRdEn, coefRdEn, macCe, macReload;
    logic [SADDR_W-1:0] smpRaddr;
    logic [CADDR_W-1:0] coefRaddr;
    logic [A_W-1:0]     smpRdata = '0;
    logic [B_W-1:0]     coefRdata = '0;
    logic [A_W-1:0]     macA;
    logic [B_W-1:0]     macB;
    logic [P_W-1:0]     macP;

    logic [A_W-1:0]        smem [SMP_DEPTH];
    logic signed [B_W-1:0] cmem [COEF_DEPTH];

    logic signed [P_W-1:0] acc = '0;
    logic signed [P_W-1:0] pipe [MAC_LAT] = '{default: '0};
    logic signed [P_W-1:0] prod;

    int nAsserts = 0;
    int nFails = 0;

    int runDone, runBusy, runReads, runAddrErr, runFirstRead, runReload, runDoneAfter;
    logic [A_W+B_W-1:0] runOps;
    logic [11:0]        runResetSnap;
    logic [OUT_W-1:0]   lastRes;
    logic               lastSat;

    mac_window_ctrl #(
        .A_W(A_W), .B_W(B_W), .P_W(P_W), .SADDR_W(SADDR_W),
        .CADDR_W(CADDR_W), .MAC_LAT(MAC_LAT), .OUT_W(OUT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .base_addr_i(baseAddr), .len_i(lenIn),
        .busy_o(busy), .done_o(done), .result_o(result), .sat_o(sat),
        .smp_rd_en_o(smpRdEn), .smp_raddr_o(smpRaddr), .smp_rdata_i(smpRdata),
        .coef_rd_en_o(coefRdEn), .coef_raddr_o(coefRaddr), .coef_rdata_i(coefRdata),
        .mac_ce_o(macCe), .mac_reload_o(macReload),
        .mac_a_o(macA), .mac_b_o(macB), .mac_p_i(macP)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the enabled read
    always @(posedge clk) begin
        if (smpRdEn) smpRdata <= smem[smpRaddr];
        if (coefRdEn) coefRdata <= cmem[coefRaddr];
    end

    // MAC core: accumulator with load-to-zero, followed by MAC_LAT output registers
    assign prod = P_W'($signed({1'b0, macA})) * P_W'($signed(macB));
    always @(posedge clk) begin
        if (macCe) begin
            acc <= (macReload ? '0 : acc) + prod;
            pipe[0] <= acc;
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign macP = pipe[MAC_LAT-1];

    // Dot product over the clamped window, then clipped to the signed result range
    function automatic void refModel(input int base, input int len,
                                     output logic [OUT_W-1:0] expRes, output logic expSat);
        longint sum = 0;
        int n = (len > COEF_DEPTH) ? COEF_DEPTH : len;
        for (int k = 0; k < n; k++)
            sum += longint'(smem[(base + k) % SMP_DEPTH]) * longint'(cmem[k]);
        if (sum > 64'sd2147483647) begin
            expRes = 32'h7FFF_FFFF; expSat = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            expRes = 32'h8000_0000; expSat = 1'b1;
        end else begin
            expRes = sum[OUT_W-1:0]; expSat = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One request; optional abort, repeated start or reset at a given cycle after the start edge
    task automatic applyStimulus(input int base, input int len, input int abortCyc,
                                 input int restartCyc, input int resetCyc);
        int n = (len > COEF_DEPTH) ? COEF_DEPTH : len;
        int budget = n + MAC_LAT + 20;
        int k = 0;
        runDone = 0; runBusy = 0; runReads = 0; runAddrErr = 0;
        runFirstRead = 0; runReload = 0; runDoneAfter = 0;
        runOps = '1; runResetSnap = '1;
        @(negedge clk);
        baseAddr = SADDR_W'(base);
        lenIn = (CADDR_W+1)'(len);
        start = 1'b1;
        for (int c = 1; c <= budget && runDone == 0; c++) begin
            @(negedge clk);
            if (busy) runBusy++;
            if (macReload && runReload == 0) runReload = c;
            if (smpRdEn) begin
                if (runFirstRead == 0) runFirstRead = c;
                if (smpRaddr !== SADDR_W'((base + k) % SMP_DEPTH) ||
                    coefRaddr !== CADDR_W'(k) || coefRdEn !== 1'b1) runAddrErr++;
                k++;
                runReads++;
            end
            if (abortCyc != 0 && c == abortCyc + 2) runOps = {macA, macB};
            if (done) runDone = c;
            start = (c == restartCyc);
            abort = (c == abortCyc);
            if (c == resetCyc) begin
                rst_n = 1'b0;
                #1;
                runResetSnap = {busy, done, sat, smpRdEn, coefRdEn, macReload, macCe,
                                |result, |macA, |macB, |smpRaddr, |coefRaddr};
            end
            if (resetCyc != 0 && c == resetCyc + 2) rst_n = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (runDone != 0) begin
            @(negedge clk);
            runDoneAfter = int'(done);
        end
    endtask

    // Standard checks for a run that is expected to complete
    task automatic checkRun(input string tag, input int base, input int len);
        logic [OUT_W-1:0] expRes;
        logic expSat;
        int n = (len > COEF_DEPTH) ? COEF_DEPTH : len;
        refModel(base, len, expRes, expSat);
        checkOutput({tag, ".doneCycle"}, 64'(runDone), 64'(n + MAC_LAT + 5));
        checkOutput({tag, ".busyCycles"}, 64'(runBusy), 64'(n + MAC_LAT + 4));
        checkOutput({tag, ".reads"}, 64'(runReads), 64'(n));
        checkOutput({tag, ".addrErrors"}, 64'(runAddrErr), 64'd0);
        checkOutput({tag, ".reloadCycle"}, 64'(runReload), 64'd1);
        if (n > 0) checkOutput({tag, ".firstRead"}, 64'(runFirstRead), 64'd2);
        checkOutput({tag, ".doneWidth"}, 64'(runDoneAfter), 64'd0);
        checkOutput({tag, ".result"}, 64'(result), 64'(expRes));
        checkOutput({tag, ".sat"}, 64'(sat), 64'(expSat));
        lastRes = expRes;
        lastSat = expSat;
    endtask

    task automatic loadBasicWindow();
        smem[0] = 8'd10; smem[1] = 8'd20; smem[2] = 8'd30; smem[3] = 8'd40;
        cmem[0] = 18'sd1; cmem[1] = -18'sd2; cmem[2] = 18'sd3; cmem[3] = -18'sd4;
    endtask

    initial begin
        for (int i = 0; i < SMP_DEPTH; i++) smem[i] = A_W'($urandom);
        for (int i = 0; i < COEF_DEPTH; i++) cmem[i] = B_W'($urandom);

        // Reset values, then clock enable rising after release
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.macCe", 64'(macCe), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset.macCeAfter", 64'(macCe), 64'd1);
        checkOutput("reset.done", 64'(done), 64'd0);

        // Basic window: -100
        loadBasicWindow();
        applyStimulus(0, 4, 0, 0, 0);
        checkRun("basic", 0, 4);
        checkOutput("basic.literal", 64'(result), 64'hFFFF_FF9C);

        // Empty window
        applyStimulus(0, 0, 0, 0, 0);
        checkRun("empty", 0, 0);

        // Ring-buffer wrap
        applyStimulus(2046, 4, 0, 0, 0);
        checkRun("wrap", 2046, 4);

        // Start repeated during FEED is ignored
        applyStimulus(0, 4, 0, 3, 0);
        checkRun("restart", 0, 4);

        // Abort in FEED: no done, result held, operands flushed
        applyStimulus(0, 4, 4, 0, 0);
        checkOutput("abort.noDone", 64'(runDone), 64'd0);
        checkOutput("abort.busyCycles", 64'(runBusy), 64'd4);
        checkOutput("abort.result", 64'(result), 64'(lastRes));
        checkOutput("abort.sat", 64'(sat), 64'(lastSat));
        checkOutput("abort.operands", 64'(runOps), 64'd0);
        applyStimulus(0, 4, 0, 0, 0);
        checkRun("afterAbort", 0, 4);
        checkOutput("afterAbort.literal", 64'(result), 64'hFFFF_FF9C);

        // Positive and negative saturation, then length clamp
        for (int i = 0; i < SMP_DEPTH; i++) smem[i] = 8'd255;
        for (int i = 0; i < COEF_DEPTH; i++) cmem[i] = 18'sd131071;
        applyStimulus(0, 256, 0, 0, 0);
        checkRun("satPos", 0, 256);
        checkOutput("satPos.literal", 64'(result), 64'h7FFF_FFFF);
        for (int i = 0; i < COEF_DEPTH; i++) cmem[i] = -18'sd131072;
        applyStimulus(0, 256, 0, 0, 0);
        checkRun("satNeg", 0, 256);
        checkOutput("satNeg.literal", 64'(result), 64'h8000_0000);
        applyStimulus(0, 300, 0, 0, 0);
        checkRun("clamp", 0, 300);

        // Reset during DRAIN, then a clean run
        loadBasicWindow();
        applyStimulus(0, 4, 0, 0, 7);
        checkOutput("midReset.outputs", 64'(runResetSnap), 64'd0);
        checkOutput("midReset.noDone", 64'(runDone), 64'd0);
        applyStimulus(0, 4, 0, 0, 0);
        checkRun("afterReset", 0, 4);

        // Randomized windows
        for (int r = 0; r < 6; r++) begin
            int base, len;
            for (int i = 0; i < SMP_DEPTH; i++) smem[i] = A_W'($urandom);
            for (int i = 0; i < COEF_DEPTH; i++) cmem[i] = B_W'($urandom);
            base = int'($urandom_range(0, SMP_DEPTH - 1));
            len = int'($urandom_range(0, 300));
            $display("[TB] random run %0d: base=%0d len=%0d", r, base, len);
            applyStimulus(base, len, 0, 0, 0);
            checkRun($sformatf("random%0d", r), base, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
